// File: rtl/mem_exception_unit.sv
// mem_exception_unit: MEM-stage exception register, interrupt qualification,
// priority select and commit/flush sequencing toward CP0.
module mem_exception_unit #(
    parameter logic [31:0] RESET_VEC_EXC = 32'hBFC0_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_delayslot_i,
    input  logic [7:0]  ex_exc_i,
    input  logic [31:0] ex_daddr_i,
    input  logic [5:0]  ext_int_i,
    input  logic        timer_int_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        mem_valid_o,
    output logic [31:0] mem_pc_o,
    output logic        cp0_en_o,
    output logic [31:0] except_type_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] badvaddr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic [5:0]  ip_o
);
    localparam logic [31:0] EXC_TYPE_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_TYPE_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_TYPE_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_TYPE_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_TYPE_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_TYPE_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_TYPE_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TYPE_ERET = 32'h0000_000e;

    typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

    state_t      state_q, state_d;
    logic        mem_valid_q, mem_valid_d, mem_ds_q, mem_ds_d;
    logic [31:0] mem_pc_q, mem_pc_d, mem_daddr_q, mem_daddr_d;
    logic [7:0]  mem_exc_q, mem_exc_d;
    logic [5:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [31:0] type_q, type_d, bad_q, bad_d;
    logic [5:0]  hw_ip;
    logic        int_req, commit;
    logic [31:0] det_type, det_bad, cur_type, cur_bad;
    logic        unused;

    assign unused = ^{cause_i[31:10], cause_i[7:0], status_i[31:16], status_i[7:2]};

    always_comb begin
        hw_ip    = {sync2_q[5] | timer_int_i, sync2_q[4:0]};
        int_req  = status_i[0] & ~status_i[1] & |({hw_ip, cause_i[9:8]} & status_i[15:8]);
        det_type = !mem_valid_q ? 32'd0 :
                   int_req      ? EXC_TYPE_INT  :
                   mem_exc_q[0] ? EXC_TYPE_ADEL :
                   mem_exc_q[1] ? EXC_TYPE_RI   :
                   mem_exc_q[2] ? EXC_TYPE_SYS  :
                   mem_exc_q[3] ? EXC_TYPE_BP   :
                   mem_exc_q[4] ? EXC_TYPE_OV   :
                   mem_exc_q[5] ? EXC_TYPE_ADEL :
                   mem_exc_q[6] ? EXC_TYPE_ADES :
                   mem_exc_q[7] ? EXC_TYPE_ERET : 32'd0;
        det_bad  = (!mem_valid_q | int_req) ? 32'd0 :
                   mem_exc_q[0]             ? mem_pc_q :
                   |mem_exc_q[4:1]          ? 32'd0 :
                   |mem_exc_q[6:5]          ? mem_daddr_q : 32'd0;
        // HOLD replays the latched decision so interrupt changes cannot alter it
        cur_type = state_q == HOLD ? type_q : state_q == DRAIN ? 32'd0 : det_type;
        cur_bad  = state_q == HOLD ? bad_q  : state_q == DRAIN ? 32'd0 : det_bad;
        commit   = state_q != DRAIN & |cur_type & ~stall_i;
        state_d  = state_q == DRAIN ? RUN : commit ? DRAIN : (|cur_type & stall_i) ? HOLD : state_q;
        type_d   = state_q == RUN ? det_type : type_q;
        bad_d    = state_q == RUN ? det_bad : bad_q;
        mem_valid_d = (commit | state_q == DRAIN) ? 1'b0 : stall_i ? mem_valid_q : ex_valid_i;
        mem_pc_d    = (commit | state_q == DRAIN) ? 32'd0 : stall_i ? mem_pc_q : ex_pc_i;
        mem_ds_d    = (commit | state_q == DRAIN) ? 1'b0 : stall_i ? mem_ds_q : ex_delayslot_i;
        mem_exc_d   = (commit | state_q == DRAIN) ? 8'd0 : stall_i ? mem_exc_q : ex_exc_i;
        mem_daddr_d = (commit | state_q == DRAIN) ? 32'd0 : stall_i ? mem_daddr_q : ex_daddr_i;
        sync1_d  = ext_int_i;
        sync2_d  = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            mem_valid_q <= 1'b0;
            mem_pc_q    <= '0;
            mem_ds_q    <= 1'b0;
            mem_exc_q   <= '0;
            mem_daddr_q <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            type_q      <= '0;
            bad_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_pc_q    <= mem_pc_d;
            mem_ds_q    <= mem_ds_d;
            mem_exc_q   <= mem_exc_d;
            mem_daddr_q <= mem_daddr_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            type_q      <= type_d;
            bad_q       <= bad_d;
        end
    end

    // during DRAIN the redirect still follows the type that just committed
    assign new_pc_o            = ((state_q == DRAIN ? type_q : cur_type) == EXC_TYPE_ERET) ? epc_i : RESET_VEC_EXC;
    assign mem_valid_o         = mem_valid_q;
    assign mem_pc_o            = mem_pc_q;
    assign cp0_en_o            = commit;
    assign except_type_o       = cur_type;
    assign current_inst_addr_o = mem_pc_q;
    assign is_in_delayslot_o   = mem_ds_q;
    assign badvaddr_o          = cur_bad;
    assign flush_o             = commit | state_q == DRAIN;
    assign ip_o                = hw_ip;
endmodule

// File: tb/tb_mem_exception_unit.sv
// tb_mem_exception_unit: directed stimulus with a cycle-level reference model
// and hand-computed literal checks.
module tb_mem_exception_unit;
    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst, stall_i, ex_valid_i, ex_delayslot_i, timer_int_i;
    logic [31:0] ex_pc_i, ex_daddr_i, status_i, cause_i, epc_i;
    logic [7:0]  ex_exc_i;
    logic [5:0]  ext_int_i;
    logic        mem_valid_o, cp0_en_o, is_in_delayslot_o, flush_o;
    logic [31:0] mem_pc_o, except_type_o, current_inst_addr_o, badvaddr_o, new_pc_o;
    logic [5:0]  ip_o;

    mem_exception_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
        .ex_delayslot_i(ex_delayslot_i), .ex_exc_i(ex_exc_i), .ex_daddr_i(ex_daddr_i),
        .ext_int_i(ext_int_i), .timer_int_i(timer_int_i), .status_i(status_i), .cause_i(cause_i),
        .epc_i(epc_i), .mem_valid_o(mem_valid_o), .mem_pc_o(mem_pc_o), .cp0_en_o(cp0_en_o),
        .except_type_o(except_type_o), .current_inst_addr_o(current_inst_addr_o),
        .is_in_delayslot_o(is_in_delayslot_o), .badvaddr_o(badvaddr_o), .flush_o(flush_o),
        .new_pc_o(new_pc_o), .ip_o(ip_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: priority list INT, ADEL-f, RI, SYS, BP, OV, ADEL-d, ADES, ERET
    int          tbl [9] = '{1, 4, 10, 8, 9, 12, 4, 5, 14};
    bit          m_on = 0;
    bit          m_v, m_ds;
    logic [31:0] m_pc, m_da, m_held, m_hbad, m_ctype;
    logic [7:0]  m_exc;
    logic [5:0]  m_s0, m_s1;
    int          m_mode;
    logic [31:0] e_type, e_bad, e_npc;
    logic [5:0]  e_ip;
    bit          e_cp0, e_flush;

    task automatic model_out();
        logic [8:0]  cond;
        logic [31:0] w_type, w_bad;
        bit          irq;
        e_ip  = {m_s1[5] | timer_int_i, m_s1[4:0]};
        irq   = status_i[0] && !status_i[1] && (({e_ip, cause_i[9:8]} & status_i[15:8]) != 0);
        cond  = {m_exc, irq};
        w_type = 0;
        w_bad  = 0;
        for (int i = 0; i < 9; i++) begin
            if (m_v && cond[i]) begin
                w_type = tbl[i];
                w_bad  = (i == 1) ? m_pc : (i == 6 || i == 7) ? m_da : 32'd0;
                break;
            end
        end
        e_type  = m_mode == 2 ? 32'd0 : m_mode == 1 ? m_held : w_type;
        e_bad   = m_mode == 2 ? 32'd0 : m_mode == 1 ? m_hbad : w_bad;
        e_cp0   = m_mode != 2 && e_type != 0 && !stall_i;
        e_flush = e_cp0 || m_mode == 2;
        e_npc   = ((m_mode == 2 ? m_ctype : e_type) == 14) ? epc_i : VEC;
    endtask

    task automatic clear_mem();
        m_v = 0; m_ds = 0; m_pc = 0; m_da = 0; m_exc = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            clear_mem();
            m_s0 = 0; m_s1 = 0; m_mode = 0; m_held = 0; m_hbad = 0; m_ctype = 0;
            m_on = 1;
        end else if (m_on) begin
            model_out();
            m_s1 = m_s0;
            m_s0 = ext_int_i;
            if (m_mode == 2) begin
                m_mode = 0;
                clear_mem();
            end else if (e_cp0) begin
                m_ctype = e_type;
                m_mode = 2;
                clear_mem();
            end else begin
                if (e_type != 0 && stall_i && m_mode == 0) begin
                    m_mode = 1; m_held = e_type; m_hbad = e_bad;
                end
                if (!stall_i) begin
                    m_v = ex_valid_i; m_pc = ex_pc_i; m_ds = ex_delayslot_i;
                    m_exc = ex_exc_i; m_da = ex_daddr_i;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            model_out();
            chk("m_valid", {31'd0, mem_valid_o}, {31'd0, m_v});
            chk("m_pc", mem_pc_o, m_pc);
            chk("m_cur", current_inst_addr_o, m_pc);
            chk("m_ds", {31'd0, is_in_delayslot_o}, {31'd0, m_ds});
            chk("m_type", except_type_o, e_type);
            chk("m_bad", badvaddr_o, e_bad);
            chk("m_cp0", {31'd0, cp0_en_o}, {31'd0, e_cp0});
            chk("m_flush", {31'd0, flush_o}, {31'd0, e_flush});
            chk("m_npc", new_pc_o, e_npc);
            chk("m_ip", {26'd0, ip_o}, {26'd0, e_ip});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        ex_valid_i = 0; ex_exc_i = 0; ex_delayslot_i = 0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [7:0] exc, input logic [31:0] da, input logic ds);
        ex_valid_i = 1; ex_pc_i = pc; ex_exc_i = exc; ex_daddr_i = da; ex_delayslot_i = ds;
    endtask

    initial begin
        rst = 1; stall_i = 0; timer_int_i = 0; ext_int_i = 0;
        status_i = 0; cause_i = 0; epc_i = 0;
        ex_pc_i = 0; ex_daddr_i = 0;
        bubble();
        cyc(); cyc();
        @(negedge clk);
        chk("rst_valid", {31'd0, mem_valid_o}, 32'd0);
        chk("rst_pc", mem_pc_o, 32'd0);
        chk("rst_cp0", {31'd0, cp0_en_o}, 32'd0);
        chk("rst_type", except_type_o, 32'd0);
        chk("rst_bad", badvaddr_o, 32'd0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_npc", new_pc_o, VEC);
        chk("rst_ip", {26'd0, ip_o}, 32'd0);
        cyc();
        rst = 0;
        // RI commit and 2-cycle flush
        issue(32'h8000_1000, 8'h02, 32'h0, 0);
        cyc(); bubble();
        @(negedge clk);
        chk("ri_type", except_type_o, 32'h0a);
        chk("ri_cp0", {31'd0, cp0_en_o}, 32'd1);
        chk("ri_cur", current_inst_addr_o, 32'h8000_1000);
        chk("ri_npc", new_pc_o, VEC);
        chk("ri_flush0", {31'd0, flush_o}, 32'd1);
        cyc();
        @(negedge clk);
        chk("ri_flush1", {31'd0, flush_o}, 32'd1);
        chk("ri_drain_cp0", {31'd0, cp0_en_o}, 32'd0);
        cyc();
        @(negedge clk);
        chk("ri_flush2", {31'd0, flush_o}, 32'd0);
        // interrupt waits through bubbles, commits on the next valid instruction
        status_i = 32'h0000_0401;
        ext_int_i = 6'h01;
        cyc(); cyc();
        @(negedge clk);
        chk("int_ip", {26'd0, ip_o}, 32'h01);
        chk("int_bubble_cp0", {31'd0, cp0_en_o}, 32'd0);
        cyc();
        issue(32'h8000_2000, 8'h00, 32'h0, 0);
        cyc();
        @(negedge clk);
        chk("int_type", except_type_o, 32'h01);
        chk("int_cp0", {31'd0, cp0_en_o}, 32'd1);
        chk("int_cur", current_inst_addr_o, 32'h8000_2000);
        chk("int_bad", badvaddr_o, 32'd0);
        cyc();
        status_i = 32'h0000_0403; ext_int_i = 0; bubble();
        cyc(); cyc(); cyc(); cyc();
        status_i = 0;
        // ADEL fetch beats ADES; priority RI over OV
        issue(32'h8000_0002, 8'h41, 32'h0000_1235, 0);
        cyc(); bubble();
        @(negedge clk);
        chk("adel_type", except_type_o, 32'h04);
        chk("adel_bad", badvaddr_o, 32'h8000_0002);
        cyc(); cyc();
        issue(32'h8000_0100, 8'h12, 32'h0000_0010, 0);
        cyc(); bubble();
        @(negedge clk);
        chk("ri_ov_type", except_type_o, 32'h0a);
        cyc(); cyc();
        // ADES held across 3 stall cycles; a late interrupt must not pre-empt it
        issue(32'h8000_3000, 8'h40, 32'h8000_0013, 0);
        cyc(); bubble();
        stall_i = 1;
        @(negedge clk);
        chk("ades_stall_cp0a", {31'd0, cp0_en_o}, 32'd0);
        chk("ades_stall_type", except_type_o, 32'h05);
        cyc();
        status_i = 32'h0000_0401; ext_int_i = 6'h01;
        @(negedge clk);
        chk("ades_stall_cp0b", {31'd0, cp0_en_o}, 32'd0);
        cyc();
        @(negedge clk);
        chk("ades_stall_cp0c", {31'd0, cp0_en_o}, 32'd0);
        cyc();
        stall_i = 0;
        @(negedge clk);
        chk("ades_cp0", {31'd0, cp0_en_o}, 32'd1);
        chk("ades_type", except_type_o, 32'h05);
        chk("ades_bad", badvaddr_o, 32'h8000_0013);
        cyc();
        ext_int_i = 0; status_i = 0;
        cyc(); cyc(); cyc(); cyc();
        // ERET in a delay slot redirects to EPC
        epc_i = 32'hBFC0_1234;
        issue(32'h8000_4000, 8'h80, 32'h0, 1);
        cyc(); bubble();
        @(negedge clk);
        chk("eret_type", except_type_o, 32'h0e);
        chk("eret_npc", new_pc_o, 32'hBFC0_1234);
        chk("eret_ds", {31'd0, is_in_delayslot_o}, 32'd1);
        chk("eret_cp0", {31'd0, cp0_en_o}, 32'd1);
        cyc(); cyc();
        // reset during DRAIN
        issue(32'h8000_5000, 8'h02, 32'h0, 0);
        cyc(); bubble();
        @(negedge clk);
        chk("rd_cp0", {31'd0, cp0_en_o}, 32'd1);
        cyc();
        rst = 1;
        @(negedge clk);
        chk("rd_flush_drain", {31'd0, flush_o}, 32'd1);
        cyc();
        rst = 0;
        @(negedge clk);
        chk("rd_flush", {31'd0, flush_o}, 32'd0);
        chk("rd_valid", {31'd0, mem_valid_o}, 32'd0);
        // reset during HOLD issues no commit
        issue(32'h8000_6000, 8'h04, 32'h0, 0);
        cyc(); bubble();
        stall_i = 1;
        cyc();
        rst = 1;
        @(negedge clk);
        chk("rh_cp0a", {31'd0, cp0_en_o}, 32'd0);
        cyc();
        rst = 0; stall_i = 0;
        @(negedge clk);
        chk("rh_cp0b", {31'd0, cp0_en_o}, 32'd0);
        chk("rh_type", except_type_o, 32'd0);
        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_exception_unit.md
# mem_exception_unit

Memory-stage exception collector for the MIPS pipeline, sitting directly upstream of the CP0 register block. It registers the EX/MEM exception bundle, synchronizes and qualifies hardware interrupts, and prioritizes everything into one exception per instruction. On commit it drives the CP0 update strobe, the exception type, EPC source and BadVAddr, plus a two-cycle pipeline flush and the redirect PC. It holds a pending exception across memory-bus stalls.

## Interface
- RESET_VEC_EXC, 32'hBFC0_0380, exception redirect target
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- stall_i  in  1  MEM stage stalled by the data bus; MEM register holds, no commit
- ex_valid_i  in  1  EX stage holds a real instruction (0 = bubble)
- ex_pc_i  in  32  EX instruction address
- ex_delayslot_i  in  1  EX instruction is in a branch delay slot
- ex_exc_i  in  8  flags: [0] ADEL fetch, [1] RI, [2] SYS, [3] BP, [4] OV, [5] ADEL data, [6] ADES data, [7] ERET
- ex_daddr_i  in  32  EX data virtual address
- ext_int_i  in  6  asynchronous hardware interrupt lines, active-high
- timer_int_i  in  1  CP0 timer interrupt
- status_i, cause_i, epc_i  in  32 each  current CP0 Status, Cause, EPC
- mem_valid_o  out  1  MEM register valid
- mem_pc_o  out  32  MEM instruction address
- cp0_en_o  out  1  CP0 exception-update strobe
- except_type_o  out  32  `EXC_TYPE_*` encoding from defines.vh; 0 = none
- current_inst_addr_o  out  32  = mem_pc_o
- is_in_delayslot_o  out  1  MEM delay-slot flag
- badvaddr_o  out  32  faulting address
- flush_o  out  1  kill IF..MEM younger instructions
- new_pc_o  out  32  redirect PC, valid while flush_o
- ip_o  out  6  synchronized IP7..IP2

## Operation
- MEM register (valid, pc, delayslot, exc, daddr): loads EX inputs when !stall_i; cleared at the commit edge and during DRAIN; holds when stall_i.
- ext_int_i goes through a 2-flop synchronizer. hw_ip = {sync[5] | timer_int_i, sync[4:0]}; ip_o = hw_ip.
- int_req = status_i[0] & ~status_i[1] & |({hw_ip, cause_i[9:8]} & status_i[15:8]).
- Only when mem_valid, priority: INT > ADEL fetch > RI > SYS > BP > OV > ADEL data > ADES > ERET. except_type_o is the winner, else 0.
- badvaddr_o: ADEL fetch -> mem_pc; ADEL/ADES data -> mem_daddr; otherwise 0.
- new_pc_o: epc_i for ERET, otherwise RESET_VEC_EXC.
- FSM states:
  - RUN: pending (type != 0) & !stall_i -> commit, go DRAIN. Pending & stall_i -> HOLD. Otherwise stay.
  - HOLD: type latched, including a sampled interrupt, so a later interrupt deassert does not cancel it and a new interrupt does not pre-empt a latched synchronous exception. Commit when !stall_i, go DRAIN.
  - DRAIN: one cycle; flush_o = 1, cp0_en_o = 0, no detection; go RUN.
- Commit cycle: cp0_en_o = 1 and flush_o = 1 for exactly one cycle.

## Timing
- Reset: state RUN; MEM register cleared; synchronizer cleared.
  - mem_valid_o = 0, mem_pc_o = 0, cp0_en_o = 0, except_type_o = 0.
  - badvaddr_o = 0, is_in_delayslot_o = 0, flush_o = 0, new_pc_o = RESET_VEC_EXC, ip_o = 0.
- Outputs are combinational from the MEM register, FSM and CP0 inputs. The CP0 update lands at the edge ending the commit cycle.
- Commit-to-redirect latency is 0 cycles. flush_o is high for 2 cycles: commit and DRAIN.
- External interrupt to ip_o: 2 cycles. ip_o to commit: 0 cycles if a valid instruction is in MEM, RUN, not stalled.
- Bubbles (mem_valid = 0) never take interrupts; the interrupt waits for the next valid instruction.
- Status EXL is already set the cycle after commit, so no double interrupt occurs.
- stall_i rising in the same cycle an exception becomes pending: no commit; enter HOLD.
- rst during HOLD/DRAIN: return to RUN immediately; no cp0_en_o is issued.

## Test plan
- ex_valid = 1, ex_pc = 32'h8000_1000, ex_exc = 8'h02 (RI), no stall -> next cycle except_type = `EXC_TYPE_RI`, cp0_en_o = 1, current_inst_addr = 32'h8000_1000, new_pc = 32'hBFC0_0380; flush_o high 2 cycles.
- Status = 32'h0000_0401, ext_int_i[0] pulses high for 4 cycles, valid instructions flowing -> ip_o[0] = 1 after 2 cycles, INT committed on the next valid MEM instruction, badvaddr = 0.
- ex_exc = 8'h41 (ADEL fetch + ADES), ex_pc = 32'h8000_0002, daddr = 32'h1235 -> type `EXC_TYPE_ADEL`, badvaddr = 32'h8000_0002.
- ADES with daddr = 32'h8000_0013 while stall_i high 3 cycles -> HOLD, cp0_en_o = 0 while stalled; single commit the cycle stall_i drops; badvaddr = 32'h8000_0013.
- ERET with epc_i = 32'hBFC0_1234, delay slot = 1 -> type `EXC_TYPE_ERET`, new_pc = 32'hBFC0_1234, is_in_delayslot_o = 1.
- rst asserted during DRAIN -> next cycle flush_o = 0, mem_valid_o = 0, state RUN.
